// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller: 16-state TAP FSM, instruction register, BYPASS/IDCODE data
// registers, SIB-network strobes and TDO mux. Define JTAG_TAP_IDCODE_EN to build IDCODE.
module jtag_tap #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] INSTR_CHAIN  = IR_WIDTH'(8)
) (
  input  logic tck,
  input  logic trst,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_en,
  input  logic chain_tdo,
  output logic shift,
  output logic capture,
  output logic update,
  output logic chain_sel,
  output logic tlr
);

`ifdef JTAG_TAP_IDCODE_EN
  localparam int unsigned IDCODE_WIDTH = 32;
  localparam logic [IR_WIDTH-1:0] IR_RST = INSTR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RST = '1;
`endif
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } state_e;

  state_e              state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                idcode_sel;
  logic                bypass_sel;
  logic                dr_tdo;

  // TAP state sequencing on tms
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      if (!tms) state_d = RTI;
      RTI:      if (tms) state_d = SEL_DR;
      SEL_DR:   state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_d = tms ? EX1_DR : SH_DR;
      SH_DR:    if (tms) state_d = EX1_DR;
      EX1_DR:   state_d = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: if (tms) state_d = EX2_DR;
      EX2_DR:   state_d = tms ? UPD_DR : SH_DR;
      UPD_DR:   state_d = tms ? SEL_DR : RTI;
      SEL_IR:   state_d = tms ? TLR : CAP_IR;
      CAP_IR:   state_d = tms ? EX1_IR : SH_IR;
      SH_IR:    if (tms) state_d = EX1_IR;
      EX1_IR:   state_d = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: if (tms) state_d = EX2_IR;
      EX2_IR:   state_d = tms ? UPD_IR : SH_IR;
      UPD_IR:   state_d = tms ? SEL_DR : RTI;
      default:  state_d = TLR;
    endcase
  end

  // Network strobes decode straight from registered state and active IR
  assign chain_sel  = (ir_q == INSTR_CHAIN);
  assign tlr        = (state_q == TLR);
  assign shift      = (state_q == SH_DR) & chain_sel;
  assign capture    = (state_q == CAP_DR) & chain_sel;
  assign update     = (state_q == UPD_DR) & chain_sel;
  assign bypass_sel = ~chain_sel & ~idcode_sel;

`ifdef JTAG_TAP_IDCODE_EN
  logic [IDCODE_WIDTH-1:0] idcode_q, idcode_d;

  assign idcode_sel = (ir_q == INSTR_IDCODE);
  assign dr_tdo     = chain_sel ? chain_tdo : (idcode_sel ? idcode_q[0] : bypass_q);

  always_comb begin
    idcode_d = idcode_q;
    if (idcode_sel && state_q == CAP_DR) idcode_d = IDCODE_VALUE;
    if (idcode_sel && state_q == SH_DR)  idcode_d = {tdi, idcode_q[IDCODE_WIDTH-1:1]};
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) idcode_q <= IDCODE_VALUE;
    else      idcode_q <= idcode_d;
  end
`else
  logic unused_idcode;

  assign idcode_sel    = 1'b0;
  assign dr_tdo        = chain_sel ? chain_tdo : bypass_q;
  assign unused_idcode = ^{IDCODE_VALUE, INSTR_IDCODE};
`endif

  // IR/BYPASS capture-shift-update and next TDO source
  always_comb begin
    ir_sr_d  = ir_sr_q;
    ir_d     = ir_q;
    bypass_d = bypass_q;
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    case (state_q)
      CAP_IR: ir_sr_d = IR_CAPTURE;
      SH_IR: begin
        ir_sr_d  = {tdi, ir_sr_q[IR_WIDTH-1:1]};
        tdo_d    = ir_sr_q[0];
        tdo_en_d = 1'b1;
      end
      UPD_IR: ir_d = ir_sr_q;
      CAP_DR: if (bypass_sel) bypass_d = 1'b0;
      SH_DR: begin
        if (bypass_sel) bypass_d = tdi;
        tdo_d    = dr_tdo;
        tdo_en_d = 1'b1;
      end
      default: ;
    endcase
    if (state_d == TLR) ir_d = IR_RST;
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state_q  <= TLR;
      ir_q     <= IR_RST;
      ir_sr_q  <= '0;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      ir_sr_q  <= ir_sr_d;
      bypass_q <= bypass_d;
    end
  end

  // TDO launches on falling tck so the far end samples it cleanly on rising tck
  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo    = tdo_q;
  assign tdo_en = tdo_en_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Bench for jtag_tap: random and directed TAP walks against a cycle-level reference model,
// with expectations queued by the driver and checked by an independent monitor.
module tb_jtag_tap;

  localparam int IRW = 4;
  localparam logic [31:0] IDCODE = 32'h1000_0001;
  localparam int OP_IDCODE = 1;
  localparam int OP_CHAIN  = 8;
`ifdef JTAG_TAP_IDCODE_EN
  localparam bit IDC_EN = 1'b1;
`else
  localparam bit IDC_EN = 1'b0;
`endif
  localparam int IR_RST = IDC_EN ? OP_IDCODE : 15;

  // Model state numbering: IR branch states are the DR branch states offset by 7
  localparam int S_TLR = 0, S_RTI = 1, S_SDR = 2, S_CDR = 3, S_SHDR = 4, S_E1DR = 5,
                 S_PDR = 6, S_E2DR = 7, S_UDR = 8, S_SIR = 9, S_CIR = 10, S_SHIR = 11,
                 S_UIR = 15, IR_OFS = 7;

  typedef struct packed {
    logic tlr; logic chain_sel; logic shift; logic capture; logic update; logic tdo_en; logic tdo;
  } obs_t;

  typedef struct {
    int          kind;
    int          n;
    logic [63:0] val;
    string       name;
  } scan_t;

  logic tck, trst, tms, tdi, tdo, tdo_en, chain_tdo, shift, capture, update, chain_sel, tlr;

  obs_t  exp_q[$];
  scan_t scan_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  int          m_st, m_ir, m_irsr;
  logic        m_byp;
  logic [31:0] m_idc;

  jtag_tap dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .chain_tdo(chain_tdo), .shift(shift), .capture(capture), .update(update),
    .chain_sel(chain_sel), .tlr(tlr)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int m_next(input int st, input logic t);
    int off;
    int d;
    case (st)
      S_TLR: return t ? S_TLR : S_RTI;
      S_RTI: return t ? S_SDR : S_RTI;
      S_SDR: return t ? S_SIR : S_CDR;
      S_SIR: return t ? S_TLR : S_CIR;
      default: begin
        off = (st >= S_CIR) ? IR_OFS : 0;
        d = st - off;
        case (d)
          S_CDR:   return (t ? S_E1DR : S_SHDR) + off;
          S_SHDR:  return (t ? S_E1DR : S_SHDR) + off;
          S_E1DR:  return (t ? S_UDR : S_PDR) + off;
          S_PDR:   return (t ? S_E2DR : S_PDR) + off;
          S_E2DR:  return (t ? S_UDR : S_SHDR) + off;
          default: return t ? S_SDR : S_RTI;
        endcase
      end
    endcase
  endfunction

  task automatic m_reset();
    m_st = S_TLR; m_ir = IR_RST; m_irsr = 0; m_byp = 1'b0; m_idc = IDCODE;
  endtask

  function automatic obs_t m_obs(input logic ctdo);
    obs_t o;
    bit cs, ids;
    o = '0;
    cs = (m_ir == OP_CHAIN);
    ids = IDC_EN && (m_ir == OP_IDCODE);
    o.tlr = (m_st == S_TLR);
    o.chain_sel = cs;
    o.shift = cs && (m_st == S_SHDR);
    o.capture = cs && (m_st == S_CDR);
    o.update = cs && (m_st == S_UDR);
    if (m_st == S_SHIR) begin
      o.tdo_en = 1'b1;
      o.tdo = m_irsr[0];
    end else if (m_st == S_SHDR) begin
      o.tdo_en = 1'b1;
      o.tdo = cs ? ctdo : (ids ? m_idc[0] : m_byp);
    end
    return o;
  endfunction

  task automatic m_advance(input logic t, input logic d);
    int nx;
    bit cs, ids;
    nx = m_next(m_st, t);
    cs = (m_ir == OP_CHAIN);
    ids = IDC_EN && (m_ir == OP_IDCODE);
    if (m_st == S_CIR) m_irsr = 1;
    if (m_st == S_SHIR) m_irsr = (m_irsr >> 1) | (int'(d) << (IRW - 1));
    if (m_st == S_UIR) m_ir = m_irsr;
    if (m_st == S_CDR && !cs) begin
      if (ids) m_idc = IDCODE;
      else m_byp = 1'b0;
    end
    if (m_st == S_SHDR && !cs) begin
      if (ids) m_idc = {d, m_idc[31:1]};
      else m_byp = d;
    end
    if (nx == S_TLR) m_ir = IR_RST;
    m_st = nx;
  endtask

  // One tck period: drive inputs after the rising edge and queue the expected outputs
  task automatic cyc(input logic t, input logic d, input logic r);
    logic c;
    c = 1'($urandom_range(0, 1));
    @(posedge tck);
    #1;
    tms = t; tdi = d; chain_tdo = c; trst = r;
    if (r) m_reset();
    exp_q.push_back(m_obs(c));
    if (!r) m_advance(t, d);
  endtask

  task automatic push_scan(input int kind, input int n, input logic [63:0] val, input string name);
    scan_t s;
    s.kind = kind; s.n = n; s.val = val; s.name = name;
    scan_q.push_back(s);
  endtask

  task automatic goto_rti();
    repeat (5) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ir_scan(input int n, input logic [63:0] din, input logic [63:0] expv,
                         input string name);
    logic [63:0] dv;
    dv = din;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    push_scan(0, 0, '0, "");
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) cyc(i == n - 1, dv[i], 1'b0);
    push_scan(1, n, expv, name);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din, input logic [63:0] expv,
                         input bit chk, input int pause_at, input string name);
    logic [63:0] dv;
    bit last, brk;
    dv = din;
    cyc(1'b1, 1'b0, 1'b0);
    push_scan(0, 0, '0, "");
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      brk = (i == pause_at - 1) && !last;
      cyc(last || brk, dv[i], 1'b0);
      if (brk) begin
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
      end
    end
    if (chk) push_scan(1, n, expv, name);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every sampled cycle and collects shifted-out tdo bits
  initial begin
    logic [63:0] cap;
    logic [63:0] msk;
    int capn, cyc_n;
    obs_t e, a;
    scan_t s;
    cap = '0; capn = 0; cyc_n = 0;
    forever begin
      @(negedge tck);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {tlr, chain_sel, shift, capture, update, tdo_en, tdo};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outputs cycle %0d: got tlr/cs/sh/cap/upd/en/tdo=%b required %b",
                   cyc_n, a, e);
        end
        cyc_n++;
      end
      if (tdo_en === 1'b1 && capn < 64) begin
        cap[capn] = tdo;
        capn++;
      end
      while (scan_q.size() > 0) begin
        s = scan_q.pop_front();
        if (s.kind == 0) begin
          cap = '0;
          capn = 0;
        end else begin
          msk = (64'd1 << s.n) - 64'd1;
          n_cmp++;
          if (capn != s.n || (cap & msk) !== (s.val & msk)) begin
            n_err++;
            $display("FAIL scan %s: got %0d bits 0x%0h required %0d bits 0x%0h",
                     s.name, capn, cap & msk, s.n, s.val & msk);
          end
        end
      end
    end
  end

  // Driver
  initial begin
    int op, len, pz;
    int ops[4];
    logic [63:0] rd;
    ops = '{OP_IDCODE, OP_CHAIN, 15, 0};
    trst = 1'b1; tms = 1'b1; tdi = 1'b0; chain_tdo = 1'b0;
    m_reset();
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    if (IDC_EN) dr_scan(32, 64'hFFFF_FFFF, 64'(IDCODE), 1'b1, 0, "idcode");
    else dr_scan(1, 64'h1, 64'h0, 1'b1, 0, "bypass_first_bit");

    goto_rti();
    ir_scan(IRW, 64'hF, 64'h1, "ir_capture");
    dr_scan(9, {55'd0, 1'b0, 8'hA5}, {55'd0, 8'hA5, 1'b0}, 1'b1, 0, "bypass_a5");

    ir_scan(IRW, 64'(OP_CHAIN), 64'h1, "ir_load_chain");
    dr_scan(12, 64'($urandom), '0, 1'b0, 5, "");
    dr_scan(1, 64'h1, '0, 1'b0, 0, "");
    ir_scan(IRW, 64'hF, 64'h1, "ir_leave_chain");
    dr_scan(3, 64'h5, 64'h2, 1'b1, 0, "bypass_after_chain");

    ir_scan(IRW, 64'(OP_CHAIN), 64'h1, "ir_chain_trst");
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      op = ops[$urandom_range(0, 3)];
      if (op == 0) op = $urandom_range(0, 15);
      goto_rti();
      ir_scan(IRW, 64'(op), 64'h1, "ir_random");
      len = $urandom_range(1, 40);
      pz = $urandom_range(0, 3) == 0 ? $urandom_range(1, len) : 0;
      rd = {32'($urandom), 32'($urandom)};
      dr_scan(len, rd, '0, 1'b0, pz, "");
      repeat (20) cyc(($urandom_range(0, 99) < 40), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 149) == 0));
    end

    repeat (800) cyc(($urandom_range(0, 99) < 35), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 299) == 0));

    repeat (3) @(posedge tck);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_tap.md
Name: jtag_tap

Overview:
- IEEE 1149.1 TAP controller that sits directly upstream of the SIB/TDR test network.
- Decodes TMS into the 16-state TAP FSM and holds a 4-bit instruction register.
- Generates the network-wide shift/capture/update strobes, qualified by the CHAIN instruction.
- Multiplexes the device TDO from the IR, BYPASS, IDCODE or SIB-chain return path.

Parameters:
- IR_WIDTH, 4, instruction register width (>=2).
- IDCODE_VALUE, 32'h1000_0001, value captured by the IDCODE data register; bit 0 must be 1.
- INSTR_IDCODE, 4'b0001, opcode selecting the IDCODE register.
- INSTR_CHAIN, 4'b1000, opcode selecting the SIB network (top SIB).

Ports:
- tck  input  1  test clock; the only clock.
- trst  input  1  asynchronous active-high reset.
- tms  input  1  test mode select, sampled on rising tck.
- tdi  input  1  test data in; feeds IR/BYPASS/IDCODE shift, and the top SIB directly at top level.
- tdo  output  1  test data out, changes on falling tck.
- tdo_en  output  1  high while tdo carries valid shift data.
- chain_tdo  input  1  serial return from the top SIB tdo.
- shift  output  1  network shift strobe.
- capture  output  1  network capture strobe.
- update  output  1  network update strobe.
- chain_sel  output  1  current instruction is INSTR_CHAIN.
- tlr  output  1  FSM is in Test-Logic-Reset.

Behaviour:
- Reset is asynchronous and active-high: trst=1 clears all state, independent of tck.
- Reset values:
  - FSM = Test-Logic-Reset.
  - IR = INSTR_IDCODE.
  - Bypass register = 0.
  - IDCODE shift register = IDCODE_VALUE.
  - tdo = 0, tdo_en = 0, shift = capture = update = 0.
  - chain_sel = 0, tlr = 1.
- FSM: the 16 standard states, advanced on rising tck by tms per 1149.1:
  - TLR -0-> RTI; RTI -1-> SelDR; SelDR -1-> SelIR, -0-> CapDR.
  - CapDR -0-> ShDR, -1-> Ex1DR; ShDR -1-> Ex1DR.
  - Ex1DR -0-> PauseDR, -1-> UpdDR; PauseDR -1-> Ex2DR; Ex2DR -0-> ShDR, -1-> UpdDR.
  - UpdDR -0-> RTI, -1-> SelDR.
  - The IR branch mirrors the DR branch; SelIR -1-> TLR.
  - Unlisted tms values hold the current state.
- Five consecutive tms=1 rising edges reach TLR from any state.
- Entering TLR through the FSM loads IR = INSTR_IDCODE, exactly as trst does.
- IR path:
  - CapIR loads the IR shift register with {0..0,01}.
  - ShIR shifts right: tdi enters the MSB, the LSB drives tdo.
  - UpdIR copies the shift register into the active IR on rising tck leaving UpdIR. The active IR never changes mid-DR-scan.
- Instruction decode:
  - IR == INSTR_CHAIN: selects the SIB network, chain_sel = 1.
  - IR == INSTR_IDCODE: selects the 32-bit IDCODE register.
  - Any other value, including all-ones: selects the 1-bit BYPASS.
- DR path:
  - CapDR: BYPASS loads 0; IDCODE loads IDCODE_VALUE.
  - ShDR: shift right, tdi into MSB.
  - The chain is shifted by the network itself; this block only strobes it.
- Strobes are combinational from the state register and active IR, glitch-free:
  - shift = ShDR & chain_sel.
  - capture = CapDR & chain_sel.
  - update = UpdDR & chain_sel.
- TDO: registered on falling tck from the source selected by the current state and IR:
  - ShIR: IR LSB.
  - ShDR: chain_tdo, IDCODE LSB, or bypass bit, per IR.
  - tdo_en is registered alongside tdo, and is 1 only for falling edges taken in ShIR/ShDR.
  - Otherwise tdo = 0, tdo_en = 0.
- Scan lengths are tck-count exact: BYPASS gives 1-bit delay, IDCODE 32, IR IR_WIDTH.
- Pause states hold every register; no strobes fire in Pause.
- trst mid-scan: the partial shift is discarded, all strobes drop immediately and tdo = 0. No update is issued.

Optional Feature:
- Macro: JTAG_TAP_IDCODE_EN.
- Defined: IDCODE register and opcode implemented as described above.
- Undefined:
  - IDCODE register is not built; INSTR_IDCODE decodes as BYPASS.
  - Reset and TLR load IR = all-ones (BYPASS).
  - IDCODE_VALUE is unused.

Test Plan:
- trst pulse mid-ShDR, then release -> tlr=1, strobes 0, tdo_en=0. Then 5x tms=1 from RTI -> still TLR; tms=0 -> RTI.
- TLR -> ShDR, shift 32 bits (macro defined) -> tdo returns 0x10000001 LSB-first. Macro undefined -> 1-bit bypass, first tdo bit 0.
- TLR -> ShIR, shift IR_WIDTH bits -> captured pattern 4'b0001 out LSB-first; load 4'b1111.
- With IR=4'b1111, shift 0xA5 through DR -> tdo reproduces 0xA5 delayed by exactly 1 tck.
- Load INSTR_CHAIN:
  - chain_sel=1.
  - capture high only in CapDR.
  - shift high for exactly N tck in ShDR, low in PauseDR.
  - update one cycle in UpdDR.
  - tdo follows chain_tdo one falling edge later.
- Load INSTR_CHAIN, then walk ShIR -> UpdIR with a new opcode -> chain_sel stays 1 until leaving UpdIR. No shift/update strobes during the IR scan.
